// File: rtl/spi_sample_seq_pkg.sv
// Shared constants and state encoding for the SPI sample sequencer.
// SB_SPI register map, status bit positions and chip-select values.
package spi_sample_seq_pkg;

    localparam logic [7:0] REG_CR1  = 8'h09;
    localparam logic [7:0] REG_CR2  = 8'h0A;
    localparam logic [7:0] REG_BR   = 8'h0B;
    localparam logic [7:0] REG_SR   = 8'h0C;
    localparam logic [7:0] REG_TXDR = 8'h0D;
    localparam logic [7:0] REG_RXDR = 8'h0E;
    localparam logic [7:0] REG_CSR  = 8'h0F;

    localparam int SR_TIP  = 7;
    localparam int SR_TRDY = 4;
    localparam int SR_RRDY = 3;

    localparam logic [7:0] CR1_SPE     = 8'h80;
    localparam logic [7:0] CSR_ASSERT  = 8'hFE;
    localparam logic [7:0] CSR_RELEASE = 8'hFF;

    typedef enum logic [3:0] {
        ST_INIT_CR1,
        ST_INIT_CR2,
        ST_INIT_BR,
        ST_INIT_CSR,
        ST_IDLE,
        ST_CS_LO,
        ST_WAIT_TRDY,
        ST_TX_HI,
        ST_TX_LO,
        ST_WAIT_RRDY,
        ST_RD_RXDR,
        ST_WAIT_TIP,
        ST_CS_HI
    } state_t;

endpackage

// File: rtl/spi_bus_access.sv
// Single-access handshake engine for the SPI wrapper's processor port.
// Holds cs/we/addr/din until bus_rdy, then drops cs for one cycle before the next access.
module spi_bus_access (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       done,
    output logic [7:0] rdata,
    output logic       bus_cs,
    output logic       bus_we,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_din,
    input  logic [7:0] bus_dout,
    input  logic       bus_rdy
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_cs   <= 1'b0;
            bus_we   <= 1'b0;
            bus_addr <= 8'h00;
            bus_din  <= 8'h00;
        end else if (bus_cs) begin
            if (bus_rdy) begin
                bus_cs <= 1'b0;
            end
        end else if (start) begin
            bus_cs   <= 1'b1;
            bus_we   <= we;
            bus_addr <= addr;
            bus_din  <= wdata;
        end
    end

    // The caller advances on this edge; the cs-low cycle that follows is the inter-access gap.
    assign done  = bus_cs & bus_rdy;
    assign rdata = bus_dout;

endmodule

// File: rtl/spi_sample_sequencer.sv
// Turns 16-bit stream samples into SB_SPI register accesses (two MSB-first bytes framed by CSR).
// Define SPI_SAMPLE_SEQ_READBACK_EN to also read back RXDR and expose rx_data/rx_valid.
module spi_sample_sequencer
    import spi_sample_seq_pkg::*;
#(
    parameter logic [7:0] BR_DIV     = 8'h02,
    parameter logic [7:0] SPICR2_VAL = 8'hC0,
    parameter int         POLL_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    output logic        bus_cs,
    output logic        bus_we,
    output logic [7:0]  bus_addr,
    output logic [7:0]  bus_din,
    input  logic [7:0]  bus_dout,
    input  logic        bus_rdy,
    output logic        init_done,
    output logic        busy,
    output logic        err
`ifdef SPI_SAMPLE_SEQ_READBACK_EN
    ,
    output logic [15:0] rx_data,
    output logic        rx_valid
`endif
);

    localparam int POLL_W = $clog2(POLL_LIMIT);

    state_t            state_reg;
    logic [15:0]       sample_reg;
    logic              hi_done_reg;
    logic [POLL_W-1:0] poll_cnt_reg;

    logic       acc_start;
    logic       acc_we;
    logic [7:0] acc_addr;
    logic [7:0] acc_wdata;
    logic       done;
    logic [7:0] rdata;
    logic       poll_last;
    logic       unused_rdata;

    assign poll_last    = (poll_cnt_reg == POLL_W'(POLL_LIMIT - 1));
    assign unused_rdata = ^rdata;

    spi_bus_access u_bus (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (acc_start),
        .we       (acc_we),
        .addr     (acc_addr),
        .wdata    (acc_wdata),
        .done     (done),
        .rdata    (rdata),
        .bus_cs   (bus_cs),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_din  (bus_din),
        .bus_dout (bus_dout),
        .bus_rdy  (bus_rdy)
    );

    // Each non-idle state is exactly one register access; polls repeat the same state.
    always_comb begin
        acc_start = 1'b1;
        acc_we    = 1'b0;
        acc_addr  = REG_SR;
        acc_wdata = 8'h00;
        case (state_reg)
            ST_INIT_CR1: begin acc_we = 1'b1; acc_addr = REG_CR1;  acc_wdata = CR1_SPE;           end
            ST_INIT_CR2: begin acc_we = 1'b1; acc_addr = REG_CR2;  acc_wdata = SPICR2_VAL;        end
            ST_INIT_BR:  begin acc_we = 1'b1; acc_addr = REG_BR;   acc_wdata = BR_DIV;            end
            ST_INIT_CSR: begin acc_we = 1'b1; acc_addr = REG_CSR;  acc_wdata = CSR_RELEASE;       end
            ST_CS_LO:    begin acc_we = 1'b1; acc_addr = REG_CSR;  acc_wdata = CSR_ASSERT;        end
            ST_TX_HI:    begin acc_we = 1'b1; acc_addr = REG_TXDR; acc_wdata = sample_reg[15:8];  end
            ST_TX_LO:    begin acc_we = 1'b1; acc_addr = REG_TXDR; acc_wdata = sample_reg[7:0];   end
            ST_CS_HI:    begin acc_we = 1'b1; acc_addr = REG_CSR;  acc_wdata = CSR_RELEASE;       end
            ST_RD_RXDR:  begin acc_addr = REG_RXDR; end
            ST_WAIT_TRDY, ST_WAIT_RRDY, ST_WAIT_TIP: begin end
            default:     begin acc_start = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_INIT_CR1;
            sample_reg   <= 16'h0000;
            hi_done_reg  <= 1'b0;
            poll_cnt_reg <= '0;
            s_ready      <= 1'b0;
            init_done    <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
`ifdef SPI_SAMPLE_SEQ_READBACK_EN
            rx_data      <= 16'h0000;
            rx_valid     <= 1'b0;
`endif
        end else begin
`ifdef SPI_SAMPLE_SEQ_READBACK_EN
            rx_valid <= 1'b0;
`endif
            case (state_reg)
                ST_INIT_CR1: if (done) state_reg <= ST_INIT_CR2;
                ST_INIT_CR2: if (done) state_reg <= ST_INIT_BR;
                ST_INIT_BR:  if (done) state_reg <= ST_INIT_CSR;
                ST_INIT_CSR: if (done) begin
                    state_reg <= ST_IDLE;
                    init_done <= 1'b1;
                    s_ready   <= 1'b1;
                end
                ST_IDLE: if (s_valid && s_ready) begin
                    sample_reg  <= s_data;
                    s_ready     <= 1'b0;
                    busy        <= 1'b1;
                    hi_done_reg <= 1'b0;
                    state_reg   <= ST_CS_LO;
                end
                ST_CS_LO: if (done) begin
                    poll_cnt_reg <= '0;
                    state_reg    <= ST_WAIT_TRDY;
                end
                ST_WAIT_TRDY: if (done) begin
                    if (rdata[SR_TRDY]) begin
                        state_reg <= hi_done_reg ? ST_TX_LO : ST_TX_HI;
                    end else if (poll_last) begin
                        err       <= 1'b1;
                        state_reg <= ST_CS_HI;
                    end else begin
                        poll_cnt_reg <= poll_cnt_reg + 1'b1;
                    end
                end
                ST_TX_HI: if (done) begin
                    poll_cnt_reg <= '0;
`ifdef SPI_SAMPLE_SEQ_READBACK_EN
                    state_reg    <= ST_WAIT_RRDY;
`else
                    hi_done_reg  <= 1'b1;
                    state_reg    <= ST_WAIT_TRDY;
`endif
                end
                ST_TX_LO: if (done) begin
                    poll_cnt_reg <= '0;
`ifdef SPI_SAMPLE_SEQ_READBACK_EN
                    state_reg    <= ST_WAIT_RRDY;
`else
                    state_reg    <= ST_WAIT_TIP;
`endif
                end
`ifdef SPI_SAMPLE_SEQ_READBACK_EN
                ST_WAIT_RRDY: if (done) begin
                    if (rdata[SR_RRDY]) begin
                        state_reg <= ST_RD_RXDR;
                    end else if (poll_last) begin
                        err       <= 1'b1;
                        state_reg <= ST_CS_HI;
                    end else begin
                        poll_cnt_reg <= poll_cnt_reg + 1'b1;
                    end
                end
                ST_RD_RXDR: if (done) begin
                    rx_data      <= {rx_data[7:0], rdata};
                    poll_cnt_reg <= '0;
                    hi_done_reg  <= 1'b1;
                    state_reg    <= hi_done_reg ? ST_WAIT_TIP : ST_WAIT_TRDY;
                end
`endif
                ST_WAIT_TIP: if (done) begin
                    if (!rdata[SR_TIP]) begin
                        state_reg <= ST_CS_HI;
                    end else if (poll_last) begin
                        err       <= 1'b1;
                        state_reg <= ST_CS_HI;
                    end else begin
                        poll_cnt_reg <= poll_cnt_reg + 1'b1;
                    end
                end
                ST_CS_HI: if (done) begin
                    busy      <= 1'b0;
                    s_ready   <= 1'b1;
                    state_reg <= ST_IDLE;
`ifdef SPI_SAMPLE_SEQ_READBACK_EN
                    rx_valid  <= 1'b1;
`endif
                end
                default: state_reg <= ST_INIT_CR1;
            endcase
        end
    end

endmodule
